alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 150 +++++++++++++++
 tb/tb_alu_multicycle.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: ALU with valid/ready handshakes. Single-cycle logic/arith ops
// complete one cycle after accept; mul (shift-add) and divu (restoring) iterate
// for WIDTH cycles.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operation handshake (in_ready only in IDLE)
//   Source1, Source2, ALU_Ctrl operands A/B (unsigned) and operation select
//   out_valid/out_ready        result handshake (out_valid only in DONE)
//   Result, Result_Hi, Zero    low/quotient result, high/remainder, Result==0
module alu_multicycle #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Source1,
    input  logic [WIDTH-1:0] Source2,
    input  logic [3:0]       ALU_Ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_Hi,
    output logic             Zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;      // partial product high half / partial remainder
    logic [WIDTH-1:0] lo_q;      // multiplier bits / dividend-quotient shift reg
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_hi_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = res_q;
    assign Result_Hi = res_hi_q;
    assign Zero      = (res_q == '0);

    // Single-cycle result computed straight from the inputs at the accept edge.
    always_comb begin
        single_res = Source1;
        case (ALU_Ctrl)
            OP_AND:  single_res = Source1 & Source2;
            OP_OR:   single_res = Source1 | Source2;
            OP_ADD:  single_res = Source1 + Source2;
            OP_SUB:  single_res = Source1 - Source2;
            OP_SLT:  single_res = WIDTH'(Source1 < Source2);
            default: single_res = Source1;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    // Divide by zero needs no special case: every trial subtract of 0 succeeds,
    // so the quotient fills with ones and the remainder ends up equal to A.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, b_q});
        rem_new = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (op_q == OP_DIVU) begin
            hi_step = rem_new;
            lo_step = {lo_q[WIDTH-2:0], rem_ge};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= ALU_Ctrl;
                        a_q   <= Source1;
                        b_q   <= Source2;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        if (ALU_Ctrl == OP_MUL) begin
                            lo_q    <= Source2;
                            state_q <= BUSY;
                        end else if (ALU_Ctrl == OP_DIVU) begin
                            lo_q    <= Source1;
                            state_q <= BUSY;
                        end else begin
                            res_q    <= single_res;
                            res_hi_q <= '0;
                            state_q  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        res_q    <= lo_step;
                        res_hi_q <= hi_step;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=16 main instance, WIDTH=8 for divide vectors).
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv = 1'b0, ir, ov, ordy = 1'b0, z;
    logic [15:0] a = '0, b = '0, res, reshi;
    logic [3:0]  op = '0;

    logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b0, z8;
    logic [7:0]  a8 = '0, b8 = '0, res8, reshi8;
    logic [3:0]  op8 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
        .Source1(a), .Source2(b), .ALU_Ctrl(op),
        .out_valid(ov), .out_ready(ordy),
        .Result(res), .Result_Hi(reshi), .Zero(z)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .Source1(a8), .Source2(b8), .ALU_Ctrl(op8),
        .out_valid(ov8), .out_ready(ordy8),
        .Result(res8), .Result_Hi(reshi8), .Zero(z8)
    );

    // Reference: {hi, lo} from plain arithmetic on the operation meaning.
    function automatic logic [31:0] ref16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        case (o)
            4'b0000: p = {16'h0, x & y};
            4'b0001: p = {16'h0, x | y};
            4'b0010: p = {16'h0, 16'((32'(x) + 32'(y)) % 32'h10000)};
            4'b0110: p = {16'h0, 16'((32'(x) + 32'h10000 - 32'(y)) % 32'h10000)};
            4'b0111: p = (x < y) ? 32'd1 : 32'd0;
            4'b1000: p = 32'(x) * 32'(y);
            4'b1001: p = (y == 0) ? {x, 16'hFFFF} : {x % y, x / y};
            default: p = {16'h0, x};
        endcase
        return p;
    endfunction

    function automatic int lat16(input logic [3:0] o);
        return (o == 4'b1000 || o == 4'b1001) ? 17 : 1;
    endfunction

    // Issue one op, hold the result 'hold' cycles under garbage input, then consume.
    task automatic run_op16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                            input int hold, input string tag);
        logic [31:0] e;
        int lat;
        bit busy_bad, hold_bad;
        e = ref16(o, x, y);
        lat = 0; busy_bad = 0; hold_bad = 0;
        @(negedge clk);
        op = o; a = x; b = y; iv = 1'b1; ordy = 1'b0;
        n_cmp++;
        if (ir !== 1'b1) begin n_bad++; $display("FAIL %s accept_ready: got %b want 1", tag, ir); end
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ov === 1'b1) begin lat = i; break; end
            if (ir !== 1'b0) busy_bad = 1;
            iv = 1'($urandom); a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
        end
        n_cmp++;
        if (lat != lat16(o)) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, lat16(o)); end
        n_cmp++;
        if (busy_bad) begin n_bad++; $display("FAIL %s busy_in_ready: got 1 want 0", tag); end
        n_cmp++;
        if ({reshi, res} !== e) begin n_bad++; $display("FAIL %s result: got %h_%h want %h_%h", tag, reshi, res, e[31:16], e[15:0]); end
        n_cmp++;
        if (z !== (e[15:0] == 16'h0)) begin n_bad++; $display("FAIL %s zero: got %b want %b", tag, z, (e[15:0] == 16'h0)); end
        n_cmp++;
        if (ir !== 1'b0) begin n_bad++; $display("FAIL %s done_in_ready: got %b want 0", tag, ir); end
        for (int j = 0; j < hold; j++) begin
            iv = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
            @(negedge clk);
            if (ov !== 1'b1 || ir !== 1'b0 || {reshi, res} !== e || z !== (e[15:0] == 16'h0)) hold_bad = 1;
        end
        if (hold > 0) begin
            n_cmp++;
            if (hold_bad) begin n_bad++; $display("FAIL %s hold_stable: got %b/%h_%h want 1/%h", tag, ov, reshi, res, e); end
        end
        // Present a valid op on the consume edge; it must not be taken there.
        ordy = 1'b1; iv = 1'b1; op = 4'b0010; a = 16'h0001; b = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0; iv = 1'b0;
        n_cmp++;
        if (ov !== 1'b0 || ir !== 1'b1) begin n_bad++; $display("FAIL %s consume_idle: got ov=%b ir=%b want ov=0 ir=1", tag, ov, ir); end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({ir, ov, res, reshi, z} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b1}) begin
            n_bad++; $display("FAIL reset_values: got ir=%b ov=%b r=%h hi=%h z=%b want 1 0 0000 0000 1", ir, ov, res, reshi, z);
        end
        // First accept on the very first rising edge after release.
        @(negedge clk);
        rst_n = 1'b1; iv = 1'b1; op = 4'b0010; a = 16'd5; b = 16'd6;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        n_cmp++;
        if (ov !== 1'b1 || res !== 16'd11) begin n_bad++; $display("FAIL first_accept: got ov=%b r=%h want 1 000b", ov, res); end
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
    endtask

    task automatic test_single_ops();
        run_op16(4'b0010, 16'hFFFF, 16'h0001, 0, "add_wrap");
        run_op16(4'b0111, 16'd3, 16'd5, 0, "slt_3_5");
        run_op16(4'b0110, 16'd5, 16'd5, 0, "sub_5_5");
        run_op16(4'b0101, 16'h1234, 16'hBEEF, 0, "pass_0101");
        run_op16(4'b0000, 16'hF0F0, 16'h3C3C, 0, "and");
        run_op16(4'b0001, 16'hF0F0, 16'h0F0F, 0, "or");
        run_op16(4'b0110, 16'h0000, 16'h0001, 0, "sub_wrap");
    endtask

    task automatic test_mul();
        run_op16(4'b1000, 16'hFFFF, 16'hFFFF, 0, "mul_max");
        run_op16(4'b1000, 16'h0000, 16'h1234, 0, "mul_zero");
        run_op16(4'b1001, 16'd40000, 16'd123, 0, "divu16");
        run_op16(4'b1001, 16'd777, 16'd0, 0, "divu16_by0");
    endtask

    task automatic test_backpressure();
        run_op16(4'b0001, 16'h00A5, 16'h5A00, 5, "bp_single");
        run_op16(4'b1000, 16'h1357, 16'h2468, 5, "bp_mul");
    endtask

    task automatic test_random();
        logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                                 4'b1000, 4'b1001, 4'b0011, 4'b1111, 4'b1010};
        logic [15:0] x, y;
        for (int k = 0; k < 40; k++) begin
            x = 16'($urandom); y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) y = 16'h0;
            if ($urandom_range(0, 7) == 0) x = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) y = x;
            run_op16(ops[$urandom_range(0, 9)], x, y, $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_reset_mid_mul();
        bit pulse;
        pulse = 0;
        run_op16(4'b0101, 16'h1234, 16'h0, 0, "pre_reset");
        @(negedge clk);
        op = 4'b1000; a = 16'hFFFF; b = 16'hFFFF; iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ir, ov, res, reshi, z} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b1}) begin
            n_bad++; $display("FAIL async_reset: got ir=%b ov=%b r=%h hi=%h z=%b want 1 0 0000 0000 1", ir, ov, res, reshi, z);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov !== 1'b0 || ir !== 1'b1) pulse = 1;
        end
        n_cmp++;
        if (pulse) begin n_bad++; $display("FAIL post_reset_quiet: got out_valid/in_ready activity want idle"); end
    endtask

    // WIDTH=8 divide vectors.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] eq, input logic [7:0] er, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        op8 = 4'b1001; a8 = x; b8 = y; iv8 = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            iv8 = 1'b0;
            if (ov8 === 1'b1) begin lat = i; break; end
        end
        n_cmp++;
        if (lat != 9) begin n_bad++; $display("FAIL %s latency: got %0d want 9", tag, lat); end
        n_cmp++;
        if (res8 !== eq || reshi8 !== er) begin n_bad++; $display("FAIL %s result: got q=%0d r=%0d want q=%0d r=%0d", tag, res8, reshi8, eq, er); end
        ordy8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy8 = 1'b0;
        n_cmp++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1) begin n_bad++; $display("FAIL %s consume: got ov=%b ir=%b want 0 1", tag, ov8, ir8); end
    endtask

    task automatic test_div8();
        run8(8'd200, 8'd7, 8'd28, 8'd4, "divu8_200_7");
        run8(8'd37, 8'd0, 8'hFF, 8'd37, "divu8_37_0");
        run8(8'd5, 8'd9, 8'd0, 8'd5, "divu8_5_9");
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_div8();
        test_backpressure();
        test_random();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
